// File: rtl/bayer_frame_framer.sv
// Bayer sensor framer: tracks row/column of incoming raw pixels, tags each with its
// CFA phase and frame/line markers, and buffers them in a first-word-fall-through FIFO.
module bayer_frame_framer #(
    parameter int DATA_W     = 12,
    parameter int DIM_W      = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_enable,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [1:0]        cfg_shift,
    input  logic              s_fs,
    input  logic              s_ls,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        m_phase,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              frame_done,
    output logic              err_overflow,
    output logic              err_line_len
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FS = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [DIM_W-1:0]   col_q, row_q, col_d, row_d;
    logic [DIM_W-1:0]   width_q, height_q;
    logic [1:0]         shift_q;
    logic               frame_done_q, err_len_q, err_ovf_q;

    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;

    logic               fs_cyc_s, accept_s, drop_len_s, push_s, pop_s, full_s;
    logic               wr_s, ovf_s, eof_s, len_err_s, sof_s, eol_s;
    logic [DIM_W-1:0]   pc_s, pr_s, eff_width_s, eff_height_s;
    logic [1:0]         eff_shift_s, phase_s;

    // Pixel position, tagging and error detection for the current input cycle
    always_comb begin
        fs_cyc_s     = cfg_enable && s_fs && (state_q == WAIT_FS || state_q == ACTIVE);
        eff_width_s  = fs_cyc_s ? cfg_width  : width_q;
        eff_height_s = fs_cyc_s ? cfg_height : height_q;
        eff_shift_s  = fs_cyc_s ? cfg_shift  : shift_q;
        len_err_s    = 1'b0;
        if (fs_cyc_s) begin
            pc_s = '0;
            pr_s = '0;
            len_err_s = (state_q == ACTIVE);
        end else if (state_q == ACTIVE && s_ls) begin
            // A line start before any pixel of the frame just opens line 0
            pc_s = '0;
            if (row_q == '0 && col_q == '0) begin
                pr_s = '0;
            end else begin
                pr_s = row_q + DIM_W'(1);
                len_err_s = (col_q != width_q);
            end
        end else begin
            pc_s = col_q;
            pr_s = row_q;
        end
        accept_s   = cfg_enable && s_valid && (state_q == ACTIVE || fs_cyc_s);
        drop_len_s = accept_s && (pc_s == eff_width_s);
        push_s     = accept_s && !drop_len_s;
        len_err_s  = len_err_s || drop_len_s;
        pop_s      = m_valid && m_ready;
        full_s     = (count_q == (AW+1)'(FIFO_DEPTH));
        wr_s       = push_s && (!full_s || pop_s);
        ovf_s      = push_s && full_s && !pop_s;
        sof_s      = (pr_s == '0) && (pc_s == '0);
        eol_s      = (pc_s == eff_width_s - DIM_W'(1));
        eof_s      = push_s && eol_s && (pr_s == eff_height_s - DIM_W'(1));
        phase_s    = {pr_s[0] ^ eff_shift_s[1], pc_s[0] ^ eff_shift_s[0]};
        col_d      = push_s ? pc_s + DIM_W'(1) : pc_s;
        row_d      = pr_s;
    end

    // Framing FSM, position counters, latched config and status flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            shift_q      <= 2'b00;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else if (!cfg_enable) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            frame_done_q <= eof_s;
            err_len_q    <= err_len_q | len_err_s;
            err_ovf_q    <= err_ovf_q | ovf_s;
            case (state_q)
                IDLE: state_q <= WAIT_FS;
                WAIT_FS, ACTIVE: begin
                    if (fs_cyc_s) begin
                        width_q  <= cfg_width;
                        height_q <= cfg_height;
                        shift_q  <= cfg_shift;
                        state_q  <= ACTIVE;
                    end
                    if (eof_s) begin
                        state_q <= WAIT_FS;
                        col_q   <= '0;
                        row_q   <= '0;
                    end else if (state_q == ACTIVE || fs_cyc_s) begin
                        col_q <= col_d;
                        row_q <= row_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; disabling the framer flushes the buffer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (!cfg_enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_s, pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are never observed while the buffer is empty
    always_ff @(posedge clock) begin
        if (wr_s) mem_q[wr_ptr_q] <= {s_data, phase_s, sof_s, eol_s, eof_s};
    end

    assign m_valid = (count_q != '0);
    assign {m_data, m_phase, m_sof, m_eol, m_eof} = m_valid ? mem_q[rd_ptr_q] : {EW{1'b0}};
    assign frame_done   = frame_done_q;
    assign err_overflow = err_ovf_q;
    assign err_line_len = err_len_q;

endmodule

// File: tb/tb_bayer_frame_framer.sv
// Directed self-checking bench for bayer_frame_framer: table-driven frame runs plus
// hand-written overflow, line-length, mid-frame restart and reset sequences.
module tb_bayer_frame_framer;

    logic        clock = 1'b0;
    logic        reset_n, cfg_enable, s_fs, s_ls, s_valid, m_ready;
    logic [11:0] cfg_width, cfg_height, s_data;
    logic [1:0]  cfg_shift;
    logic        m_valid, m_sof, m_eol, m_eof, frame_done, err_overflow, err_line_len;
    logic [11:0] m_data;
    logic [1:0]  m_phase;
    int          total = 0;
    int          bad = 0;

    typedef struct packed {
        logic        fs, ls, vld;
        logic [11:0] data;
        logic        ev;
        logic [11:0] ed;
        logic [1:0]  ep;
        logic        esof, eeol, eeof, edone;
    } vec_t;

    vec_t vt [9];

    bayer_frame_framer dut (
        .clock(clock), .reset_n(reset_n), .cfg_enable(cfg_enable),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_shift(cfg_shift),
        .s_fs(s_fs), .s_ls(s_ls), .s_valid(s_valid), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_phase(m_phase),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .frame_done(frame_done),
        .err_overflow(err_overflow), .err_line_len(err_line_len)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic fs, input logic ls, input logic vld, input logic [11:0] d);
        s_fs = fs; s_ls = ls; s_valid = vld; s_data = d;
    endtask

    task automatic restart(input logic [11:0] w, input logic [11:0] h);
        drive(1'b0, 1'b0, 1'b0, 12'd0);
        cfg_enable = 1'b0;
        tick();
        cfg_enable = 1'b1; cfg_width = w; cfg_height = h; cfg_shift = 2'b00;
        tick();
    endtask

    task automatic run_table(input logic [1:0] shift);
        cfg_shift = shift;
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].fs, vt[i].ls, vt[i].vld, vt[i].data);
            tick();
            if (i == 1) cfg_shift = ~shift;
            check($sformatf("t%0d_valid[%0d]", shift, i), m_valid, vt[i].ev);
            check($sformatf("t%0d_done[%0d]", shift, i), frame_done, vt[i].edone);
            if (vt[i].ev) begin
                check($sformatf("t%0d_data[%0d]", shift, i), m_data, vt[i].ed);
                check($sformatf("t%0d_phase[%0d]", shift, i), m_phase, vt[i].ep ^ shift);
                check($sformatf("t%0d_tags[%0d]", shift, i), {m_sof, m_eol, m_eof},
                      {vt[i].esof, vt[i].eeol, vt[i].eeof});
            end
        end
        cfg_shift = shift;
        check("table_err_len", err_line_len, 1'b0);
    endtask

    initial begin
        //        fs    ls    vld   data    ev    ed      ep     sof   eol   eof   done
        vt[0] = '{1'b1, 1'b0, 1'b1, 12'd1, 1'b1, 12'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 12'd2, 1'b1, 12'd2, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 12'd3, 1'b1, 12'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 12'd4, 1'b1, 12'd4, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 12'd5, 1'b1, 12'd5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 12'd6, 1'b1, 12'd6, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b1, 12'd7, 1'b1, 12'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 12'd8, 1'b1, 12'd8, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[8] = '{1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0; cfg_enable = 1'b0; m_ready = 1'b1;
        cfg_width = 12'd4; cfg_height = 12'd2; cfg_shift = 2'b00;
        drive(1'b0, 1'b0, 1'b0, 12'd0);
        tick(); tick();
        check("rst_outs", {m_valid, m_sof, m_eol, m_eof, frame_done, err_overflow, err_line_len}, 7'd0);
        check("rst_data", {m_data, m_phase}, 14'd0);
        reset_n = 1'b1;
        cfg_enable = 1'b1;
        tick();

        // Basic frame, then the same frame with both shift bits set
        run_table(2'b00);
        run_table(2'b11);

        // Overflow: 10 pixels into an 8-deep buffer with downstream stalled
        cfg_width = 12'd16; m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, 1'b0, 1'b1, 12'd100 + 12'(i));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 12'd0);
        check("ovf_flag", err_overflow, 1'b1);
        check("ovf_hold", {m_valid, m_data, m_sof}, {1'b1, 12'd100, 1'b1});
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain[%0d]", k), {m_valid, m_data}, {1'b1, 12'd100 + 12'(k)});
            tick();
        end
        check("drain_empty", m_valid, 1'b0);
        cfg_enable = 1'b0;
        tick();
        check("disable_clears", {err_overflow, err_line_len}, 2'b00);

        // Fifth pixel of a 4-wide line is dropped
        restart(12'd4, 12'd4);
        for (int i = 1; i <= 5; i++) begin
            drive(i == 1, 1'b0, 1'b1, 12'(i));
            tick();
            if (i == 4) check("line_eol", {m_data, m_eol, err_line_len}, {12'd4, 1'b1, 1'b0});
        end
        check("drop5", {m_valid, err_line_len}, {1'b0, 1'b1});

        // Short line: s_ls after 3 pixels
        restart(12'd4, 12'd4);
        for (int i = 1; i <= 3; i++) begin
            drive(i == 1, 1'b0, 1'b1, 12'(i));
            tick();
        end
        check("short_pre", err_line_len, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 12'd5);
        tick();
        check("short_err", {err_line_len, m_data, m_phase}, {1'b1, 12'd5, 2'b10});

        // Mid-frame s_fs restarts at (0,0)
        restart(12'd4, 12'd2);
        for (int i = 1; i <= 3; i++) begin
            drive(i == 1, 1'b0, 1'b1, 12'(i));
            tick();
        end
        check("midfs_pre", err_line_len, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 12'd50);
        tick();
        check("midfs_sof", {err_line_len, m_data, m_sof, m_phase}, {1'b1, 12'd50, 1'b1, 2'b00});
        drive(1'b0, 1'b0, 1'b1, 12'd51);
        tick();
        check("midfs_next", {m_data, m_sof, m_phase}, {12'd51, 1'b0, 2'b01});

        // Asynchronous reset with 4 pixels buffered and a sticky error set
        restart(12'd16, 12'd2);
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(i == 1 || i == 3, 1'b0, 1'b1, 12'(i));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 12'd0);
        check("pre_rst", {m_valid, m_data, err_line_len}, {1'b1, 12'd1, 1'b1});
        reset_n = 1'b0;
        #2;
        check("async_rst", {m_valid, m_data, m_sof, frame_done, err_overflow, err_line_len}, 17'd0);
        tick();
        reset_n = 1'b1; m_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 1'b1, 12'd77);
        tick(); tick();
        check("no_fs_ignored", m_valid, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 12'd78);
        tick();
        check("post_rst_frame", {m_valid, m_data, m_sof}, {1'b1, 12'd78, 1'b1});
        drive(1'b0, 1'b0, 1'b0, 12'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
